// File: rtl/buzz_detector.sv
// Buzz detector: decodes a differential buzz pair and measures each buzz
// (last complete half-period, toggle count, active duration). Reports a
// clean end with a one-cycle done pulse and malformed/stuck signals with a
// one-cycle fault pulse. Results update only on done.
module buzz_detector #(
    parameter int MAX_HALF          = 65_535,
    parameter int MAX_HALF_TURBOSIM = 63,
    parameter int MAX_TOGGLES       = 1_023,
    parameter int MAX_DUR           = 16_777_215,
    parameter int TOL               = 2,
    localparam int HALF_W = $clog2(MAX_HALF + 1),
    localparam int TOG_W  = $clog2(MAX_TOGGLES + 1),
    localparam int DUR_W  = $clog2(MAX_DUR + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              turbosim,
    input  logic              sig_p,
    input  logic              sig_n,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [HALF_W-1:0] half_period,
    output logic [TOG_W-1:0]  toggles,
    output logic [DUR_W-1:0]  duration,
    output logic              irregular
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        WAIT_IDLE = 2'd2
    } state_t;

    localparam logic [1:0] CODE_IDLE    = 2'b00;
    localparam logic [1:0] CODE_LEVEL0  = 2'b01;
    localparam logic [1:0] CODE_LEVEL1  = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL = 2'b11;

    localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);
    localparam logic [HALF_W-1:0] TOL_V     = HALF_W'(TOL);
    localparam logic [TOG_W-1:0]  TOG_MAX_V = TOG_W'(MAX_TOGGLES);
    localparam logic [DUR_W-1:0]  DUR_MAX_V = DUR_W'(MAX_DUR);

    state_t              state_q, state_d;
    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic                lvl_prev_q, lvl_prev_d;
    logic [HALF_W-1:0]   cnt_half_q, cnt_half_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [TOG_W-1:0]    tog_cnt_q, tog_cnt_d;
    logic [HALF_W-1:0]   ref_half_q, ref_half_d;
    logic                ref_valid_q, ref_valid_d;
    logic                irr_q, irr_d;
    logic [HALF_W-1:0]   last_half_q, last_half_d;
    logic [HALF_W-1:0]   half_period_q, half_period_d;
    logic [TOG_W-1:0]    toggles_q, toggles_d;
    logic [DUR_W-1:0]    duration_q, duration_d;
    logic                irregular_q, irregular_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;

    // Synchronised code (s_p, s_n) and the derived per-cycle conditions.
    logic [1:0]          code;
    logic                toggle;
    logic [HALF_W-1:0]   half_limit;
    logic [HALF_W-1:0]   half_dev;
    logic [DUR_W-1:0]    dur_inc;
    logic [TOG_W-1:0]    tog_inc;

    assign code       = sync2_q;
    assign toggle     = (sync2_q[1] != lvl_prev_q);
    assign half_limit = turbosim ? HALF_W'(MAX_HALF_TURBOSIM) : HALF_W'(MAX_HALF);
    assign half_dev   = (cnt_half_q >= ref_half_q) ? (cnt_half_q - ref_half_q)
                                                   : (ref_half_q - cnt_half_q);
    assign dur_inc    = (dur_cnt_q == DUR_MAX_V) ? dur_cnt_q : dur_cnt_q + DUR_W'(1);
    assign tog_inc    = (tog_cnt_q == TOG_MAX_V) ? tog_cnt_q : tog_cnt_q + TOG_W'(1);

    // Next-state, measurement and output-pulse logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        sync1_d       = {sig_p, sig_n};
        sync2_d       = sync1_q;
        lvl_prev_d    = sync2_q[1];
        state_d       = state_q;
        cnt_half_d    = cnt_half_q;
        dur_cnt_d     = dur_cnt_q;
        tog_cnt_d     = tog_cnt_q;
        ref_half_d    = ref_half_q;
        ref_valid_d   = ref_valid_q;
        irr_d         = irr_q;
        last_half_d   = last_half_q;
        half_period_d = half_period_q;
        toggles_d     = toggles_q;
        duration_d    = duration_q;
        irregular_d   = irregular_q;
        done_d        = 1'b0;
        fault_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (code == CODE_LEVEL0 || code == CODE_LEVEL1) begin
                    state_d     = ACTIVE;
                    cnt_half_d  = HALF_ONE;
                    dur_cnt_d   = DUR_W'(1);
                    tog_cnt_d   = '0;
                    ref_valid_d = 1'b0;
                    irr_d       = 1'b0;
                    last_half_d = '0;
                end else if (code == CODE_ILLEGAL) begin
                    fault_d = 1'b1;
                    state_d = WAIT_IDLE;
                end
            end
            ACTIVE: begin
                if (code == CODE_ILLEGAL) begin
                    fault_d = 1'b1;
                    state_d = WAIT_IDLE;
                end else if (code == CODE_IDLE) begin
                    done_d        = 1'b1;
                    state_d       = IDLE;
                    half_period_d = last_half_q;
                    toggles_d     = tog_cnt_q;
                    duration_d    = dur_cnt_q;
                    irregular_d   = irr_q;
                end else if (toggle) begin
                    // The half that just completed becomes the reference if
                    // it is the first one, otherwise it is checked against it.
                    if (!ref_valid_q) begin
                        ref_half_d  = cnt_half_q;
                        ref_valid_d = 1'b1;
                    end else if (half_dev > TOL_V) begin
                        irr_d = 1'b1;
                    end
                    last_half_d = cnt_half_q;
                    cnt_half_d  = HALF_ONE;
                    tog_cnt_d   = tog_inc;
                    dur_cnt_d   = dur_inc;
                end else if (cnt_half_q == half_limit) begin
                    fault_d = 1'b1;
                    state_d = WAIT_IDLE;
                end else begin
                    cnt_half_d = cnt_half_q + HALF_ONE;
                    dur_cnt_d  = dur_inc;
                end
            end
            WAIT_IDLE: begin
                if (code == CODE_IDLE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and measurement registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (reset) begin
            state_q       <= IDLE;
            sync1_q       <= CODE_IDLE;
            sync2_q       <= CODE_IDLE;
            lvl_prev_q    <= 1'b0;
            cnt_half_q    <= '0;
            dur_cnt_q     <= '0;
            tog_cnt_q     <= '0;
            ref_half_q    <= '0;
            ref_valid_q   <= 1'b0;
            irr_q         <= 1'b0;
            last_half_q   <= '0;
            half_period_q <= '0;
            toggles_q     <= '0;
            duration_q    <= '0;
            irregular_q   <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            lvl_prev_q    <= lvl_prev_d;
            cnt_half_q    <= cnt_half_d;
            dur_cnt_q     <= dur_cnt_d;
            tog_cnt_q     <= tog_cnt_d;
            ref_half_q    <= ref_half_d;
            ref_valid_q   <= ref_valid_d;
            irr_q         <= irr_d;
            last_half_q   <= last_half_d;
            half_period_q <= half_period_d;
            toggles_q     <= toggles_d;
            duration_q    <= duration_d;
            irregular_q   <= irregular_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
        end
    end

    assign busy        = (state_q == ACTIVE);
    assign done        = done_q;
    assign fault       = fault_q;
    assign half_period = half_period_q;
    assign toggles     = toggles_q;
    assign duration    = duration_q;
    assign irregular   = irregular_q;

endmodule
